// File: rtl/spike_select_network.sv
// Snapshots a packed ternary spike vector on start and emits a burst of randomly
// chosen {spike value, neuron id} words over valid/ready, ids drawn from an LFSR.
module spike_select_network #(
  parameter int                         TEN_DATA_WIDTH  = 2,
  parameter int                         NUM_NEURON      = 256,
  parameter int                         NEURON_ID_WIDTH = 8,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_TAPS       = 8'hB8,
  parameter logic [NEURON_ID_WIDTH-1:0] LFSR_SEED       = 8'h8B,
  parameter int                         PICK_WIDTH      = 8,
  parameter int                         MAX_RETRY       = 3
) (
  input  logic                                   clk,
  input  logic                                   reset_l,
  input  logic                                   en_step,
  input  logic                                   start,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]   spike_in,
  input  logic [NEURON_ID_WIDTH:0]               num_active,
  input  logic [PICK_WIDTH-1:0]                  num_picks,
  input  logic                                   seed_load,
  input  logic [NEURON_ID_WIDTH-1:0]             lfsr_seed,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out,
  output logic                                   busy,
  output logic                                   done
);
  localparam int TW = TEN_DATA_WIDTH;
  localparam int IW = NEURON_ID_WIDTH;
  localparam int NW = NEURON_ID_WIDTH + 1;
  localparam int SW = TEN_DATA_WIDTH * NUM_NEURON;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EMIT, S_DONE} state_t;

  state_t                state_q;
  logic [IW-1:0]         lfsr_q;
  logic [SW-1:0]         snap_q;
  logic [NW-1:0]         na_q;
  logic [RW-1:0]         retry_q;
  logic [PICK_WIDTH-1:0] picks_left_q;
  logic                  out_valid_q;
  logic [TW+IW-1:0]      spike_out_q;
  logic                  done_q;

  logic [IW-1:0] lfsr_d;
  logic [IW-1:0] na_m1;
  logic [IW-1:0] mask_w;
  logic [IW-1:0] cand_w;
  logic [IW-1:0] pick_id;
  logic [TW-1:0] pick_val;
  logic [NW-1:0] na_clamp;
  logic          cand_ok;
  logic          accept;

  // Power-of-two-minus-one mask covering every value up to v.
  function automatic logic [IW-1:0] smear(input logic [IW-1:0] v);
    logic [IW-1:0] m;
    m = v;
    for (int i = 0; i < IW; i++) m = m | (m >> 1);
    return m;
  endfunction

  assign lfsr_d   = {lfsr_q[IW-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign na_m1    = IW'(na_q - NW'(1));
  assign mask_w   = smear(na_m1);
  assign cand_w   = lfsr_d & mask_w;
  assign cand_ok  = {1'b0, cand_w} < na_q;
  assign accept   = cand_ok || (retry_q == RW'(MAX_RETRY));
  // A rejected candidate lies in [na, 2*na), so subtracting na always lands in range.
  assign pick_id  = cand_ok ? cand_w : (cand_w - na_q[IW-1:0]);
  assign pick_val = snap_q[pick_id*TW +: TW];
  assign na_clamp = (num_active == '0 || num_active > NW'(NUM_NEURON)) ?
                    NW'(NUM_NEURON) : num_active;

  assign out_valid = out_valid_q;
  assign spike_out = spike_out_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      snap_q       <= '0;
      na_q         <= '0;
      retry_q      <= '0;
      picks_left_q <= '0;
      out_valid_q  <= 1'b0;
      spike_out_q  <= '0;
      done_q       <= 1'b0;
    end else if (en_step) begin
      case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q <= (lfsr_seed == '0) ? IW'(1) : lfsr_seed;
          end else if (start) begin
            snap_q       <= spike_in;
            na_q         <= na_clamp;
            retry_q      <= '0;
            picks_left_q <= num_picks;
            if (num_picks == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          lfsr_q <= lfsr_d;
          if (accept) begin
            spike_out_q <= {pick_val, pick_id};
            out_valid_q <= 1'b1;
            retry_q     <= '0;
            state_q     <= S_EMIT;
          end else begin
            retry_q <= retry_q + RW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            picks_left_q <= picks_left_q - PICK_WIDTH'(1);
            if (picks_left_q == PICK_WIDTH'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SEARCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_select_network.sv
// Directed bench for spike_select_network: default instance plus a MAX_RETRY=0 instance.
module tb_spike_select_network;
  logic         clk = 1'b0;
  logic         reset_l;
  logic         en_step;
  logic         start;
  logic [511:0] spike_in;
  logic [8:0]   num_active;
  logic [7:0]   num_picks;
  logic         seed_load;
  logic [7:0]   lfsr_seed;
  logic         out_ready;

  logic         vld_a, busy_a, done_a;
  logic [9:0]   spk_a;
  logic         vld_b, busy_b, done_b;
  logic [9:0]   spk_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  spike_select_network u_dut (
    .clk(clk), .reset_l(reset_l), .en_step(en_step), .start(start),
    .spike_in(spike_in), .num_active(num_active), .num_picks(num_picks),
    .seed_load(seed_load), .lfsr_seed(lfsr_seed), .out_valid(vld_a),
    .out_ready(out_ready), .spike_out(spk_a), .busy(busy_a), .done(done_a)
  );

  spike_select_network #(.MAX_RETRY(0)) u_dut0 (
    .clk(clk), .reset_l(reset_l), .en_step(en_step), .start(start),
    .spike_in(spike_in), .num_active(num_active), .num_picks(num_picks),
    .seed_load(seed_load), .lfsr_seed(lfsr_seed), .out_valid(vld_b),
    .out_ready(out_ready), .spike_out(spk_b), .busy(busy_b), .done(done_b)
  );

  function automatic logic [511:0] pattern(input bit inv);
    logic [511:0] p;
    for (int i = 0; i < 256; i++) p[i*2 +: 2] = inv ? ~2'(i % 4) : 2'(i % 4);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_l    = 1'b0;
    en_step    = 1'b1;
    start      = 1'b0;
    seed_load  = 1'b0;
    lfsr_seed  = 8'h00;
    out_ready  = 1'b1;
    num_active = 9'd256;
    num_picks  = 8'd0;
    spike_in   = pattern(1'b0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", vld_a, 0);
    chk("rst_spike", spk_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);

    // Test 1: two picks over full population
    num_picks = 8'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_valid_c1", vld_a, 0);
    chk("t1_busy_c1", busy_a, 1);
    step();
    chk("t1_valid_c2", vld_a, 1);
    chk("t1_pick0", spk_a, 10'h216);
    step();
    chk("t1_valid_gap", vld_a, 0);
    step();
    chk("t1_pick1", spk_a, 10'h12D);
    chk("t1_valid_p1", vld_a, 1);
    chk("t1_done_early", done_a, 0);
    step();
    chk("t1_done", done_a, 1);
    chk("t1_busy_done", busy_a, 1);
    step();
    chk("t1_done_clr", done_a, 0);
    chk("t1_busy_clr", busy_a, 0);

    // Tests 2/3: num_active=20, rejection vs. fallback
    do_reset();
    num_active = 9'd20;
    num_picks  = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_valid_c1", vld_a, 0);
    chk("t3_valid_c1", vld_b, 0);
    step();
    chk("t2_valid_c2", vld_a, 0);
    chk("t3_valid_c2", vld_b, 1);
    chk("t3_fallback", spk_b, 10'h202);
    step();
    chk("t2_valid_c3", vld_a, 1);
    chk("t2_pick", spk_a, 10'h10D);

    // Test 4: backpressure with en_step and spike_in toggling
    do_reset();
    num_picks = 8'd2;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t4_pick0", spk_a, 10'h216);
    for (int i = 0; i < 5; i++) begin
      en_step  = i[0];
      spike_in = pattern(i[0] ? 1'b0 : 1'b1);
      step();
      chk("t4_hold_valid", vld_a, 1);
      chk("t4_hold_spike", spk_a, 10'h216);
    end
    spike_in  = pattern(1'b1);
    en_step   = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t4_noen_valid", vld_a, 1);
    en_step = 1'b1;
    step();
    chk("t4_xfer_valid", vld_a, 0);
    step();
    chk("t4_pick1", spk_a, 10'h12D);

    // Test 5: seed_load of 0 (with concurrent start ignored), then zero-pick burst
    do_reset();
    seed_load = 1'b1;
    lfsr_seed = 8'h00;
    num_picks = 8'd1;
    start = 1'b1;
    step();
    seed_load = 1'b0;
    start = 1'b0;
    chk("t5_start_ignored", busy_a, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_valid", vld_a, 1);
    chk("t5_pick", spk_a, 10'h202);
    step();
    chk("t5_done", done_a, 1);
    step();
    num_picks = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_zero_done", done_a, 1);
    chk("t5_zero_valid", vld_a, 0);
    step();
    chk("t5_zero_done_clr", done_a, 0);
    chk("t5_zero_busy", busy_a, 0);

    // Test 6: asynchronous reset mid-EMIT
    do_reset();
    num_picks = 8'd2;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t6_pre_valid", vld_a, 1);
    #2 reset_l = 1'b0;
    #1;
    chk("t6_rst_valid", vld_a, 0);
    chk("t6_rst_spike", spk_a, 0);
    chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_done", done_a, 0);
    @(negedge clk);
    reset_l = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t6_restart_pick", spk_a, 10'h216);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/spike_select_network.md
Name: spike_select_network

Overview:
- Parametrised successor to the 2-bit spike mux network.
- On start, snapshots the packed ternary spike vector. Emits NUM_PICKS randomly chosen {spike value, neuron id} words over a valid/ready handshake.
- Neuron ids come from a configurable Fibonacci LFSR. Rejection sampling restricts ids to an arbitrary active-neuron count (not just powers of two).
- Sits between the neuron array and the synapse/update stage, gated by the top-level step enable.

Parameters:
TEN_DATA_WIDTH, 2, bits per neuron spike value
NUM_NEURON, 256, neurons in spike_in
NEURON_ID_WIDTH, 8, id width; also the LFSR width
LFSR_TAPS, 8'hB8, tap mask; feedback = XOR of state bits whose tap bit is 1
LFSR_SEED, 8'h8B, LFSR reset value; must be nonzero
PICK_WIDTH, 8, width of num_picks
MAX_RETRY, 3, rejected candidates allowed before fallback

Ports:
clk  in  1  clock
reset_l  in  1  asynchronous active-low reset
en_step  in  1  global step enable; all state updates qualified by it
start  in  1  begin a pick burst; sampled in IDLE only
spike_in  in  TEN_DATA_WIDTH*NUM_NEURON  packed spike values, neuron i at bits [i*TW+:TW]
num_active  in  NEURON_ID_WIDTH+1  active neuron count; 0 or >NUM_NEURON is treated as NUM_NEURON
num_picks  in  PICK_WIDTH  picks per burst
seed_load  in  1  load lfsr_seed; honoured in IDLE only
lfsr_seed  in  NEURON_ID_WIDTH  seed value; 0 loads 1
out_valid  out  1  spike_out valid
out_ready  in  1  consumer accepts
spike_out  out  TEN_DATA_WIDTH+NEURON_ID_WIDTH  {value, id}
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the burst finishes

Behaviour:
- Reset (async, reset_l=0): state IDLE, lfsr=LFSR_SEED, snapshot=0, out_valid=0, spike_out=0, done=0, busy=0, retry=0, picks_left=0. Asserting reset mid-burst aborts the burst; no done pulse.
- Nothing advances when en_step=0; outputs hold. A transfer occurs only when en_step & out_valid & out_ready.
- LFSR step: fb = ^(lfsr & LFSR_TAPS); lfsr_next = {lfsr[W-2:0], fb}.
- Candidate: cand = lfsr_next & mask, where mask = OR-smear of (num_active_q-1). Example: 20 -> 19 -> mask 31.
- Acceptance: accept if cand < num_active_q. If the candidate is rejected while retry==MAX_RETRY, accept cand-num_active_q instead; this is always < num_active_q.
- IDLE:
  - seed_load has priority over start in the same cycle; start is then ignored.
  - On start, latch spike_in, clamped num_active and num_picks, and clear retry.
  - num_picks==0: go to DONE directly.
  - Otherwise: picks_left=num_picks, go to SEARCH.
- SEARCH (one LFSR step per enabled cycle):
  - On accept: latch id, register spike_out={snapshot[id], id}, set out_valid=1, retry=0, go to EMIT.
  - On reject: retry++ and stay in SEARCH.
- EMIT:
  - Hold spike_out and out_valid stable until a transfer; the LFSR does not advance.
  - On transfer: out_valid=0, picks_left--. If picks_left reaches 0, go to DONE, otherwise to SEARCH.
- DONE: done=1 for one enabled cycle, then return to IDLE.
- start or seed_load while busy is ignored. spike_in changes after start do not affect the burst.
- Latency: with immediate accept and en_step held high, out_valid rises 2 cycles after start is sampled. Each rejection adds 1 cycle. Back-to-back picks cost at least 2 cycles each (EMIT + SEARCH).
- The same id may repeat within a burst; sampling is with replacement.

Test Plan:
1. Reset, num_active=256, num_picks=2, spike_in value(i)=i%4, start with out_ready=1 -> spike_out {2,22} (0x16) then {1,45} (0x2D); done pulses once; busy falls the cycle after done.
2. Same stimulus with num_active=20 -> candidate 22 rejected, 13 accepted. First out_valid appears 3 cycles after start, spike_out={1,13}.
3. MAX_RETRY=0, num_active=20 -> candidate 22 triggers fallback to id 2, spike_out={2,2}, 2 cycles after start.
4. out_ready low for 5 cycles during EMIT; toggle spike_in and en_step -> spike_out and out_valid stay stable; the LFSR does not advance; the next id after release is still 45.
5. seed_load with lfsr_seed=0 in IDLE, then start with num_active=256 and 1 pick -> lfsr loads 1, first id=2. A start with num_picks=0 -> done 1 cycle after start, no out_valid.
6. Assert reset_l low asynchronously mid-EMIT -> out_valid, spike_out, busy and done are 0 immediately; the next burst restarts from LFSR_SEED (first id 22).
